// File: rtl/obi_ext_mem_responder.sv
// OBI responder backed by a word-addressed SRAM, with a programmable grant stall
// and a fixed-latency in-order response pipeline.
module obi_ext_mem_responder #(
  parameter int          NUM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          STALL_CYCLES = 0,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] ERR_RDATA    = 32'hBADACCE5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int          AW    = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN  = 32'(NUM_WORDS * 4);
  localparam logic [3:0]  STALL = 4'(STALL_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   rd_data;
  logic [31:0]   mem [NUM_WORDS];

  logic          vld_p   [LATENCY];
  logic [31:0]   rdata_p [LATENCY];

  // Grant stall FSM: an abandoned request drops back to IDLE with nothing granted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i) begin
          if (STALL_CYCLES == 0) begin
            gnt_o = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      default: begin
        if (!req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STALL) begin
          gnt_o   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the range test.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign widx     = offset[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rd_data = we_i ? 32'h0 : (in_range ? mem[widx] : ERR_RDATA);

  // Stage 0 captures at the grant edge; the last stage drives the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= gnt_o;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_p[0] <= rd_data;
    for (int i = 1; i < LATENCY; i++) rdata_p[i] <= rdata_p[i-1];
  end

  assign rvalid_o = vld_p[LATENCY-1];
  assign rdata_o  = vld_p[LATENCY-1] ? rdata_p[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_obi_ext_mem_responder.sv
// Bench for obi_ext_mem_responder: three configurations driven one at a time,
// responses checked against a reference memory through a tagged scoreboard.
module tb_obi_ext_mem_responder;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  logic [31:0] model [3][16];
  exp_t        sb [$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  obi_ext_mem_responder #(.NUM_WORDS(16), .BASE_ADDR(32'h0), .STALL_CYCLES(0), .LATENCY(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));

  obi_ext_mem_responder #(.NUM_WORDS(16), .BASE_ADDR(32'h1000_0000), .STALL_CYCLES(3), .LATENCY(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

  obi_ext_mem_responder #(.NUM_WORDS(16), .BASE_ADDR(32'h0), .STALL_CYCLES(0), .LATENCY(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? 32'h1000_0000 : 32'h0;
  endfunction

  function automatic int stall_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Issue one request, wait for its grant, and record the expected response.
  task automatic req_txn(input int i, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
    int          waited;
    logic [31:0] off;
    logic [3:0]  widx;
    logic        inr;
    logic [31:0] e;
    exp_t        t;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    waited = 0;
    forever begin
      @(negedge clk);
      if (gnt[i]) break;
      waited++;
      if (waited > 40) begin
        check_val("gnt_timeout", gnt[i], 1);
        break;
      end
    end
    check_val("gnt_wait", waited, stall_of(i));
    off  = a - base_of(i);
    inr  = off < 32'd64;
    widx = off[5:2];
    if (w) begin
      if (inr) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) model[i][widx][8*k +: 8] = d[8*k +: 8];
      end
      e = 32'h0;
    end else begin
      e = inr ? model[i][widx] : 32'hBADACCE5;
    end
    t.inst = i; t.data = e; t.due = cyc + lat_of(i);
    sb.push_back(t);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Response monitor: order, data and exact arrival cycle per instance.
  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) check_val("gnt_without_req", gnt[i], 0);
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].inst == i) begin
            idx = j;
            break;
          end
        end
        if (rvalid[i]) begin
          if (idx < 0) begin
            check_val("rvalid_spurious", rvalid[i], 0);
          end else begin
            check_val("rdata", rdata[i], sb[idx].data);
            check_val("rvalid_cycle", cyc, sb[idx].due);
            sb.delete(idx);
          end
        end else begin
          check_val("rdata_idle_zero", rdata[i], 0);
          if (idx >= 0 && sb[idx].due <= cyc) begin
            check_val("rvalid_missing", rvalid[i], 1);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_gnt", gnt[i], 0);
      check_val("rst_rvalid", rvalid[i], 0);
      check_val("rst_rdata", rdata[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No stall, latency 1: write then read back-to-back.
    req_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    req_txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    req_txn(0, 1'b0, 4'hF, 32'h13, 32'h0);
    req_txn(0, 1'b1, 4'h0, 32'h10, 32'h12345678);
    req_txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    // Byte lanes.
    req_txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    req_txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    req_txn(0, 1'b0, 4'hF, 32'h20, 32'h0);
    // Out of range, then word 0 unchanged.
    req_txn(0, 1'b1, 4'hF, 32'h0, 32'h5A5A5A5A);
    req_txn(0, 1'b0, 4'hF, 32'h40, 32'h0);
    req_txn(0, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
    req_txn(0, 1'b0, 4'hF, 32'h0, 32'h0);
    req_txn(0, 1'b0, 4'hF, 32'h3C, 32'h0);
    drain();

    // Stall 3, latency 2, non-zero base.
    req_txn(1, 1'b1, 4'hF, 32'h1000_0004, 32'hCAFEF00D);
    req_txn(1, 1'b0, 4'hF, 32'h1000_0004, 32'h0);
    req_txn(1, 1'b0, 4'hF, 32'h1000_0040, 32'h0);
    req_txn(1, 1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0);
    drain();
    // Request abandoned mid-stall must not be granted; the next one pays full stall.
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h1000_0004;
    repeat (2) begin
      @(negedge clk);
      check_val("abandon_gnt", gnt[1], 0);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    req_txn(1, 1'b0, 4'hF, 32'h1000_0004, 32'h0);
    drain();

    // Latency 4, full throughput.
    for (int w = 0; w < 4; w++) req_txn(2, 1'b1, 4'hF, 32'(w * 4), 32'(w));
    drain();
    for (int w = 0; w < 4; w++) req_txn(2, 1'b0, 4'hF, 32'(w * 4), 32'h0);
    drain();

    // Reset with responses in flight.
    for (int w = 0; w < 4; w++) req_txn(2, 1'b0, 4'hF, 32'(w * 4), 32'h0);
    check_val("pre_reset_rvalid", rvalid[2], 1);
    rst_n = 1'b0;
    #1;
    check_val("reset_rvalid_drop", rvalid[2], 0);
    check_val("reset_rdata_drop", rdata[2], 0);
    for (int j = sb.size() - 1; j >= 0; j--)
      if (sb[j].inst == 2) sb.delete(j);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int w = 0; w < 4; w++) req_txn(2, 1'b0, 4'hF, 32'(w * 4), 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
